mem_responder: RTL and testbench

//  Memory-side responder for the multi-cycle CPU's data/instruction port. Accepts one

---
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a word-wide synchronous RAM, byte/half
// read-modify-write stores and a fixed number of wait states before each response.
//
// state  | meaning
// IDLE   | ready for a request (after the first post-reset edge)
// ERR    | rejected request (misaligned or reserved size), RAM untouched
// RD     | RAM read of the captured word address
// WAIT   | wait-state countdown before write-back or response
// WR     | merge store data into the read word and write it back
// RESP   | one-cycle response pulse
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ERR  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]            state;
    logic                  started;
    logic                  cap_write;
    logic [1:0]            cap_size;
    logic [1:0]            cap_lane;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic [31:0]           cap_wdata;
    logic                  cap_err;
    logic [3:0]            wait_cnt;
    logic [31:0]           last_rdata;
    logic                  last_err;
    logic [31:0]           data_q;
    logic [31:0]           merged;
    logic [31:0]           wide;
    logic [3:0]            lane_en;
    logic                  req_bad;
    logic [31:0]           mem [0:DEPTH-1];

    // Address bits above the RAM index are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign req_bad = (req_size == 2'b11)
                   || (req_size == 2'b00 && req_addr[1:0] != 2'b00)
                   || (req_size == 2'b01 && req_addr[0]);

    assign req_ready  = (state == S_IDLE) && started;
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = resp_valid ? data_q : last_rdata;
    assign resp_err   = resp_valid ? cap_err : last_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            started    <= 1'b0;
            cap_write  <= 1'b0;
            cap_size   <= 2'b00;
            cap_lane   <= 2'b00;
            cap_idx    <= '0;
            cap_wdata  <= '0;
            cap_err    <= 1'b0;
            wait_cnt   <= '0;
            last_rdata <= '0;
            last_err   <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        cap_write <= req_write;
                        cap_size  <= req_size;
                        cap_lane  <= req_addr[1:0];
                        cap_idx   <= req_addr[ADDR_WIDTH+1:2];
                        cap_wdata <= req_wdata;
                        cap_err   <= req_bad;
                        state     <= req_bad ? S_ERR : S_RD;
                    end
                end
                S_ERR: state <= S_RESP;
                S_RD: begin
                    if (WAIT_STATES > 0) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end else begin
                        state <= cap_write ? S_WR : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= cap_write ? S_WR : S_RESP;
                    else wait_cnt <= wait_cnt - 4'd1;
                end
                S_WR: state <= S_RESP;
                S_RESP: begin
                    last_rdata <= data_q;
                    last_err   <= cap_err;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Store data is replicated across lanes so the lane enables alone pick the target.
    always_comb begin
        lane_en = 4'b0000;
        wide    = cap_wdata;
        case (cap_size)
            2'b00: lane_en = 4'b1111;
            2'b01: begin
                lane_en = cap_lane[1] ? 4'b1100 : 4'b0011;
                wide    = {2{cap_wdata[15:0]}};
            end
            2'b10: begin
                lane_en = 4'b0001 << cap_lane;
                wide    = {4{cap_wdata[7:0]}};
            end
            default: lane_en = 4'b0000;
        endcase
        merged = data_q;
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) merged[8*k +: 8] = wide[8*k +: 8];
        end
    end

    // RAM and its read register carry no reset so contents survive a reset.
    always_ff @(posedge clock) begin
        case (state)
            S_RD:  data_q <= mem[cap_idx];
            S_WR: begin
                mem[cap_idx] <= merged;
                data_q       <= merged;
            end
            S_ERR: data_q <= '0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stores, loads, sub-word merges, errors, reset abort, wrap.
module tb_mem_responder;

    localparam int W      = 1;
    localparam int LD_LAT = 2 + W;
    localparam int ST_LAT = 3 + W;
    localparam int ER_LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clock = ~clock;

    // Runs one access; request fields are scrambled after acceptance to show they are ignored.
    task automatic access(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat, output logic pulse_ok);
        int guard;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = s; req_addr = a; req_wdata = d;
        guard = 0;
        while (!req_ready && guard < 10) begin @(negedge clock); guard++; end
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = ~w; req_size = s ^ 2'b01; req_addr = ~a; req_wdata = ~d;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clock); #1;
        pulse_ok = !resp_valid && req_ready && (resp_rdata === rd) && (resp_err === er);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, pk; int lat;
        access(1'b1, 2'b00, 32'h30, 32'h0BADF00D, rd, er, lat, pk);
        @(negedge clock);
        reset = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            total++;
            if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_hold[%0d] got rdy=%b vld=%b err=%b rdata=%h exp 0/0/0/0", i,
                         req_ready, resp_valid, resp_err, resp_rdata);
            end
        end
        @(negedge clock);
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clock); #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        access(1'b0, 2'b00, 32'h30, 32'h0, rd, er, lat, pk);
        total++;
        if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL reset_nowrite got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_word();
        vec_t v[2];
        logic [31:0] rd; logic er, pk; int lat;
        v[0] = '{1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, ST_LAT};
        v[1] = '{1'b0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, LD_LAT};
        foreach (v[i]) begin
            access(v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, pk);
            total++;
            if (rd !== v[i].exp_rd || er !== v[i].exp_err) begin
                bad++; $display("FAIL word[%0d] data got=%h/%b exp=%h/%b", i, rd, er, v[i].exp_rd, v[i].exp_err);
            end
            total++;
            if (lat !== v[i].exp_lat) begin bad++; $display("FAIL word[%0d] latency got=%0d exp=%0d", i, lat, v[i].exp_lat); end
            total++;
            if (pk !== 1'b1) begin bad++; $display("FAIL word[%0d] pulse/hold got=%b exp=1", i, pk); end
        end
    endtask

    task automatic test_subword();
        vec_t v[5];
        logic [31:0] rd; logic er, pk; int lat;
        v[0] = '{1'b1, 2'b10, 32'h12, 32'hFFFFFFAA, 32'hDEAABEEF, 1'b0, ST_LAT};
        v[1] = '{1'b1, 2'b01, 32'h10, 32'hABCD1234, 32'hDEAA1234, 1'b0, ST_LAT};
        v[2] = '{1'b0, 2'b00, 32'h10, 32'h0,        32'hDEAA1234, 1'b0, LD_LAT};
        v[3] = '{1'b1, 2'b10, 32'h11, 32'h0000005A, 32'hDEAA5A34, 1'b0, ST_LAT};
        v[4] = '{1'b0, 2'b01, 32'h12, 32'h0,        32'hDEAA5A34, 1'b0, LD_LAT};
        foreach (v[i]) begin
            access(v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, pk);
            total++;
            if (rd !== v[i].exp_rd || er !== v[i].exp_err) begin
                bad++; $display("FAIL subword[%0d] data got=%h/%b exp=%h/%b", i, rd, er, v[i].exp_rd, v[i].exp_err);
            end
            total++;
            if (lat !== v[i].exp_lat) begin bad++; $display("FAIL subword[%0d] latency got=%0d exp=%0d", i, lat, v[i].exp_lat); end
        end
    endtask

    task automatic test_errors();
        vec_t v[5];
        logic [31:0] rd; logic er, pk; int lat;
        v[0] = '{1'b1, 2'b00, 32'h14, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, ST_LAT};
        v[1] = '{1'b0, 2'b01, 32'h11, 32'h0,        32'h0,        1'b1, ER_LAT};
        v[2] = '{1'b1, 2'b00, 32'h16, 32'hFFFFFFFF, 32'h0,        1'b1, ER_LAT};
        v[3] = '{1'b1, 2'b11, 32'h14, 32'h00000000, 32'h0,        1'b1, ER_LAT};
        v[4] = '{1'b0, 2'b00, 32'h14, 32'h0,        32'hCAFEF00D, 1'b0, LD_LAT};
        foreach (v[i]) begin
            access(v[i].w, v[i].s, v[i].a, v[i].d, rd, er, lat, pk);
            total++;
            if (rd !== v[i].exp_rd || er !== v[i].exp_err) begin
                bad++; $display("FAIL err[%0d] data got=%h/%b exp=%h/%b", i, rd, er, v[i].exp_rd, v[i].exp_err);
            end
            total++;
            if (lat !== v[i].exp_lat) begin bad++; $display("FAIL err[%0d] latency got=%0d exp=%0d", i, lat, v[i].exp_lat); end
            total++;
            if (pk !== 1'b1) begin bad++; $display("FAIL err[%0d] pulse/hold got=%b exp=1", i, pk); end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er, pk; int lat;
        access(1'b1, 2'b00, 32'h20, 32'h11112222, rd, er, lat, pk);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL wait_reset_hold got rdy=%b vld=%b exp 0/0", req_ready, resp_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL wait_reset_ready got=%b exp=1", req_ready); end
        access(1'b0, 2'b00, 32'h20, 32'h0, rd, er, lat, pk);
        total++;
        if (rd !== 32'h11112222) begin bad++; $display("FAIL wait_reset_nowrite got=%h exp=11112222", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er, pk; int lat;
        access(1'b1, 2'b00, 32'h00000400, 32'h00000055, rd, er, lat, pk);
        access(1'b0, 2'b00, 32'h00000000, 32'h0, rd, er, lat, pk);
        total++;
        if (rd !== 32'h00000055 || er !== 1'b0) begin
            bad++; $display("FAIL wrap got=%h/%b exp=00000055/0", rd, er);
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0) begin
            bad++; $display("FAIL power_on_reset got rdy=%b vld=%b err=%b rdata=%h exp 0/0/0/0",
                            req_ready, resp_valid, resp_err, resp_rdata);
        end
        @(negedge clock);
        reset = 1'b1;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_reset_in_wait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
